fire_squeeze_sequencer: RTL and testbench

Controller that sequences one fire-squeeze convolution layer.
- Gates the input pixel stream into the MAC array.
- Generates the weight-ROM address, the per-pixel accumulator clear and output sample strobes.
- Counts output pixels, then holds a done flag until the output RAM acknowledges.
- Sits between the layer-chaining control and a squeeze datapath (weight ROM, DSP_NO MACs, bias/ReLU stage).

---
 rtl/fire_seq_pkg.sv | 20 ++
 rtl/fire_seq_mod_counter.sv | 59 +++++
 rtl/fire_squeeze_sequencer.sv | 152 +++++++++++++++
 tb/tb_fire_squeeze_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fire_seq_pkg.sv
// Shared types and constants for the fire-squeeze layer sequencer.
// Imported by the sequencer top and by its counter sub-module.
package fire_seq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        DRAIN    = 2'd2,
        WAIT_ACK = 2'd3
    } fire_seq_state_t;

    // Strobe latencies relative to the last beat of a MAC window
    localparam int CLR_LAT    = 1;
    localparam int SAMPLE_LAT = 2;

    function automatic int mac_len(input int kernel_dim, input int chin);
        return kernel_dim * kernel_dim * chin;
    endfunction

endpackage

// File: rtl/fire_seq_mod_counter.sv
// Modulo-N counter with async active-low clear, sync clear and enable.
// In SATURATE mode the count stops at N instead of wrapping to zero.
module fire_seq_mod_counter #(
    parameter int N        = 4,
    parameter int W        = 2,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [W-1:0] TOP  = W'(N);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         at_last_s;

    assign at_last_s = (count_q == LAST);
    // wrap_o flags the enabled step that completes the N-th count
    assign wrap_o    = en_i && !clr_i && at_last_s;
    assign count_o   = count_q;

    // next-count selection: clear, then wrap or saturate, then hold
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            if (SATURATE) begin
                if (count_q != TOP) begin
                    count_d = count_q + W'(1);
                end else begin
                    count_d = count_q;
                end
            end else if (at_last_s) begin
                count_d = '0;
            end else begin
                count_d = count_q + W'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fire_squeeze_sequencer.sv
// Sequences one fire-squeeze convolution layer: gates the ifm stream into the
// MAC array, drives the weight-ROM address and per-pixel clear/sample strobes.
module fire_squeeze_sequencer
    import fire_seq_pkg::*;
#(
    parameter int WOUT       = 32,
    parameter int CHIN       = 128,
    parameter int KERNEL_DIM = 1,
    parameter int ADDR_W     = (mac_len(KERNEL_DIM, CHIN) > 1) ? $clog2(mac_len(KERNEL_DIM, CHIN)) : 1,
    parameter int PIX_W      = $clog2(WOUT * WOUT) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ifm_valid,
    output logic              layer_en,
    output logic [ADDR_W-1:0] rom_address,
    output logic              clr_pulse,
    output logic              sample,
    output logic [PIX_W-1:0]  pix_count,
    output logic              busy,
    output logic              done,
    input  logic              ram_feedback
);

    localparam int MAC_LEN = mac_len(KERNEL_DIM, CHIN);
    localparam int MAC_W   = (MAC_LEN > 1) ? $clog2(MAC_LEN) : 1;
    localparam int NPIX    = WOUT * WOUT;
    localparam int GAP     = SAMPLE_LAT - CLR_LAT;
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NPIX - 1);

    fire_seq_state_t state_q;
    fire_seq_state_t state_d;

    logic [MAC_W-1:0] mac_cnt_s;
    logic             mac_wrap_s;
    logic [PIX_W-1:0] pix_cnt_s;
    logic             pix_last_s;
    logic             accept_s;
    logic             launch_s;
    logic             last_beat_s;
    logic [PIX_W-1:0] pix_seen_s;

    logic             clr_pulse_q;
    logic [GAP-1:0]   sample_pipe_q;
    logic             last_sample_q;
    logic             busy_q;
    logic             done_q;

    assign accept_s = (state_q == RUN) && ifm_valid;
    assign launch_s = (state_q == IDLE) && start;

    // pix_count lags the beat stream by the clear strobe, so add it back to
    // know which pixel the current window belongs to
    assign pix_seen_s  = pix_cnt_s + {{(PIX_W-1){1'b0}}, clr_pulse_q};
    assign last_beat_s = accept_s && mac_wrap_s && (pix_seen_s == LAST_PIX);

    fire_seq_mod_counter #(
        .N        (MAC_LEN),
        .W        (MAC_W),
        .SATURATE (1'b0)
    ) u_mac_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .clr_i   (launch_s),
        .en_i    (accept_s),
        .count_o (mac_cnt_s),
        .wrap_o  (mac_wrap_s)
    );

    fire_seq_mod_counter #(
        .N        (NPIX),
        .W        (PIX_W),
        .SATURATE (1'b1)
    ) u_pix_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .clr_i   (launch_s),
        .en_i    (clr_pulse_q),
        .count_o (pix_cnt_s),
        .wrap_o  (pix_last_s)
    );

    // layer control next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last_beat_s) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (last_sample_q) begin
                    state_d = WAIT_ACK;
                end else begin
                    state_d = DRAIN;
                end
            end
            WAIT_ACK: begin
                if (ram_feedback) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_ACK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state, strobe pipeline and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            clr_pulse_q   <= 1'b0;
            sample_pipe_q <= '0;
            last_sample_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            clr_pulse_q      <= accept_s && mac_wrap_s;
            sample_pipe_q[0] <= clr_pulse_q;
            for (int i = 1; i < GAP; i++) begin
                sample_pipe_q[i] <= sample_pipe_q[i-1];
            end
            last_sample_q    <= pix_last_s;
            busy_q           <= (state_d == RUN) || (state_d == DRAIN);
            done_q           <= (state_d == WAIT_ACK);
        end
    end

    assign layer_en    = accept_s;
    assign rom_address = ADDR_W'(mac_cnt_s);
    assign clr_pulse   = clr_pulse_q;
    assign sample      = sample_pipe_q[GAP-1];
    assign pix_count   = pix_cnt_s;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_fire_squeeze_sequencer.sv
// Scoreboard bench: stimulus feeds a layer-level model that queues expected
// events; a negedge monitor pops and compares whenever the DUT presents one.
module tb_fire_squeeze_sequencer;

    localparam int WOUT = 2;
    localparam int CHIN = 4;
    localparam int KD   = 1;
    localparam int ML   = KD * KD * CHIN;
    localparam int NPIX = WOUT * WOUT;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_WAIT  = 3;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       ifm_valid;
    logic       ram_feedback;
    logic       layer_en;
    logic [1:0] rom_address;
    logic       clr_pulse;
    logic       sample;
    logic [2:0] pix_count;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    ev_t beat_q[$];
    ev_t clr_q[$];
    ev_t smp_q[$];
    ev_t done_q[$];
    ev_t ack_q[$];
    ev_t start_q[$];

    int m_mode  = M_IDLE;
    int m_beats = 0;
    int m_drain = 0;
    int exp_len  = 0;
    int exp_busy = 0;
    int exp_done = 0;
    bit chk_en   = 1'b0;

    fire_squeeze_sequencer #(
        .WOUT       (WOUT),
        .CHIN       (CHIN),
        .KERNEL_DIM (KD)
    ) dut (
        .clk          (clk),
        .rst          (rst_n),
        .start        (start),
        .ifm_valid    (ifm_valid),
        .layer_en     (layer_en),
        .rom_address  (rom_address),
        .clr_pulse    (clr_pulse),
        .sample       (sample),
        .pix_count    (pix_count),
        .busy         (busy),
        .done         (done),
        .ram_feedback (ram_feedback)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, expv);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_layer_en"}, layer_en, 0);
        chk({tag, "_rom_address"}, rom_address, 0);
        chk({tag, "_clr_pulse"}, clr_pulse, 0);
        chk({tag, "_sample"}, sample, 0);
        chk({tag, "_pix_count"}, pix_count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic model_reset();
        beat_q.delete(); clr_q.delete(); smp_q.delete();
        done_q.delete(); ack_q.delete(); start_q.delete();
        m_mode = M_IDLE; m_beats = 0; m_drain = 0;
        exp_len = 0; exp_busy = 0; exp_done = 0;
    endtask

    // Drive one cycle of inputs and advance the layer-level model
    task automatic step(input logic s, input logic v, input logic f);
        @(posedge clk); #1;
        start = s; ifm_valid = v; ram_feedback = f;
        exp_busy = (m_mode == M_RUN || m_mode == M_DRAIN) ? 1 : 0;
        exp_done = (m_mode == M_WAIT) ? 1 : 0;
        exp_len  = (m_mode == M_RUN && v) ? 1 : 0;
        chk_en   = 1'b1;
        case (m_mode)
            M_IDLE: if (s) begin
                start_q.push_back('{cyc + 1, 0});
                m_beats = 0;
                m_mode  = M_RUN;
            end
            M_RUN: if (v) begin
                beat_q.push_back('{cyc, m_beats % ML});
                m_beats++;
                if (m_beats % ML == 0) begin
                    clr_q.push_back('{cyc + 1, 0});
                    smp_q.push_back('{cyc + 2, m_beats / ML});
                end
                if (m_beats == ML * NPIX) begin
                    done_q.push_back('{cyc + 3, 1});
                    m_mode  = M_DRAIN;
                    m_drain = 2;
                end
            end
            M_DRAIN: begin
                m_drain--;
                if (m_drain == 0) m_mode = M_WAIT;
            end
            M_WAIT: if (f) begin
                ack_q.push_back('{cyc + 1, 0});
                m_mode = M_IDLE;
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    // vmode 0: continuous ifm_valid, 1: stalls before beats 2 and 9, 2: random
    task automatic run_layer(input int vmode, input int hold);
        int  st = 0;
        bit  s2 = 1'b0;
        bit  s9 = 1'b0;
        int  guard = 0;
        logic v;
        step(1'b1, 1'($urandom % 2), 1'($urandom % 2));
        while (m_mode != M_WAIT && guard < 400) begin
            guard++;
            v = 1'b1;
            if (vmode == 1) begin
                if (st > 0) begin
                    v = 1'b0; st--;
                end else if (m_mode == M_RUN && ((m_beats == 2 && !s2) || (m_beats == 9 && !s9))) begin
                    v = 1'b0; st = 2;
                    if (m_beats == 2) s2 = 1'b1; else s9 = 1'b1;
                end
            end else if (vmode == 2) begin
                v = ($urandom % 3 != 0);
            end
            step(1'($urandom % 4 == 0), v, 1'($urandom % 2));
        end
        if (guard >= 400) chk("run_timeout", 1, 0);
        for (int i = 0; i < hold; i++) step(1'($urandom % 2), 1'b1, 1'b0);
        step(1'($urandom % 2), 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'($urandom % 2), 1'($urandom % 2));
    endtask

    // Monitor: level checks plus event pops whenever the DUT presents one
    initial begin
        ev_t e;
        logic busy_p = 1'b0;
        logic done_p = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && chk_en) begin
                chk("layer_en", layer_en, exp_len);
                chk("busy", busy, exp_busy);
                chk("done", done, exp_done);
                if (layer_en) begin
                    if (beat_q.size() == 0) chk("beat_unexpected", 1, 0);
                    else begin
                        e = beat_q.pop_front();
                        chk("beat_cycle", cyc, e.cyc);
                        chk("rom_address", rom_address, e.val);
                    end
                end
                if (clr_pulse) begin
                    if (clr_q.size() == 0) chk("clr_unexpected", 1, 0);
                    else begin
                        e = clr_q.pop_front();
                        chk("clr_cycle", cyc, e.cyc);
                    end
                end
                if (sample) begin
                    if (smp_q.size() == 0) chk("sample_unexpected", 1, 0);
                    else begin
                        e = smp_q.pop_front();
                        chk("sample_cycle", cyc, e.cyc);
                        chk("pix_count_at_sample", pix_count, e.val);
                    end
                end
                if (done && !done_p) begin
                    if (done_q.size() == 0) chk("done_unexpected", 1, 0);
                    else begin
                        e = done_q.pop_front();
                        chk("done_rise_cycle", cyc, e.cyc);
                        chk("pix_count_at_done", pix_count, NPIX);
                    end
                end
                if (!done && done_p) begin
                    if (ack_q.size() == 0) chk("done_fall_unexpected", 1, 0);
                    else begin
                        e = ack_q.pop_front();
                        chk("done_fall_cycle", cyc, e.cyc);
                    end
                end
                if (busy && !busy_p) begin
                    if (start_q.size() == 0) chk("start_unexpected", 1, 0);
                    else begin
                        e = start_q.pop_front();
                        chk("start_cycle", cyc, e.cyc);
                        chk("pix_count_cleared", pix_count, 0);
                        chk("rom_address_cleared", rom_address, 0);
                    end
                end
            end
            busy_p = busy;
            done_p = done;
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; ifm_valid = 1'b0; ram_feedback = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
        run_layer(0, 20);
        run_layer(1, 3);
        for (int r = 0; r < 3; r++) run_layer(2, int'($urandom_range(0, 6)));

        // reset in the middle of a window: 6 beats -> rom_address 2, pix_count 1
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("pre_reset_rom_address", rom_address, m_beats % ML);
        chk("pre_reset_pix_count", pix_count, m_beats / ML);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("async_reset");
        @(posedge clk); #1;
        check_zero("held_reset");
        rst_n = 1'b1;
        run_layer(0, 2);

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        chk("beats_pending", beat_q.size(), 0);
        chk("clr_pending", clr_q.size(), 0);
        chk("sample_pending", smp_q.size(), 0);
        chk("done_pending", done_q.size(), 0);
        chk("ack_pending", ack_q.size(), 0);
        chk("start_pending", start_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
